// File: rtl/memory_write_align.sv
// memory_write_align: splits byte-addressed writes of 1..4 bytes into one or
// two lane-aligned dword beats and queues them for a simple bus master.
module memory_write_align #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_do,
  input  logic [31:0] wr_address,
  input  logic [2:0]  wr_length,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  output logic        bus_write_do,
  output logic [29:0] bus_address,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_data,
  input  logic        bus_write_done,
  output logic        queue_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  beat_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           done_q, done_d;
  logic           empty_q, empty_d;

  logic [3:0]     len_mask;
  logic [7:0]     be_wide;
  logic [63:0]    data_wide;
  logic [3:0]     end_off;
  logic [CW-1:0]  beats;
  logic [CW-1:0]  free_cnt;
  logic           accept;
  logic           pop;
  beat_t          beat1, beat2;

  // Beat formation from the request: shifted mask and data span two dwords.
  always_comb begin
    len_mask  = 4'b0000;
    beats     = '0;
    case (wr_length)
      3'd1: len_mask = 4'b0001;
      3'd2: len_mask = 4'b0011;
      3'd3: len_mask = 4'b0111;
      3'd4: len_mask = 4'b1111;
      default: len_mask = 4'b0000;
    endcase
    be_wide   = {4'b0000, len_mask} << wr_address[1:0];
    data_wide = {32'h0, wr_data} << {wr_address[1:0], 3'b000};
    end_off   = {2'b00, wr_address[1:0]} + {1'b0, wr_length};
    if (wr_length >= 3'd1 && wr_length <= 3'd4)
      beats = (end_off > 4'd4) ? CW'(2) : CW'(1);
    beat1.addr = wr_address[31:2];
    beat1.be   = be_wide[3:0];
    beat1.data = data_wide[31:0];
    beat2.addr = wr_address[31:2] + 30'd1;
    beat2.be   = be_wide[7:4];
    beat2.data = data_wide[63:32];
  end

  // Acceptance, pop and pointer/occupancy next-state.
  always_comb begin
    free_cnt = CW'(DEPTH) - count_q;
    // The free check deliberately ignores a same-cycle pop.
    accept   = wr_do && !done_q && (free_cnt >= beats);
    pop      = bus_write_done && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    done_d   = accept;
    if (accept)
      wr_ptr_d = wr_ptr_q + beats[PW-1:0];
    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
    count_d  = count_q + (accept ? beats : '0) - (pop ? CW'(1) : '0);
    empty_d  = (count_d == '0) && !done_d;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      empty_q  <= empty_d;
    end
  end

  // Beat storage; both beats of a split request land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (beats != '0)
        mem_q[wr_ptr_q] <= beat1;
      if (beats == CW'(2))
        mem_q[wr_ptr_q + PW'(1)] <= beat2;
    end
  end

  // Head presentation, forced to zero while the queue is empty.
  always_comb begin
    bus_write_do   = (count_q != '0);
    bus_address    = '0;
    bus_byteenable = '0;
    bus_data       = '0;
    if (bus_write_do) begin
      bus_address    = mem_q[rd_ptr_q].addr;
      bus_byteenable = mem_q[rd_ptr_q].be;
      bus_data       = mem_q[rd_ptr_q].data;
    end
  end

  assign wr_done     = done_q;
  assign queue_empty = empty_q;

endmodule

// File: tb/tb_memory_write_align.sv
// Directed bench for memory_write_align with hand-computed expectations.
module tb_memory_write_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_do;
  logic [31:0] wr_address;
  logic [2:0]  wr_length;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        bus_write_do;
  logic [29:0] bus_address;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_data;
  logic        bus_write_done;
  logic        queue_empty;

  int n_checks = 0;
  int n_fail   = 0;

  memory_write_align #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_do          (wr_do),
    .wr_address     (wr_address),
    .wr_length      (wr_length),
    .wr_data        (wr_data),
    .wr_done        (wr_done),
    .bus_write_do   (bus_write_do),
    .bus_address    (bus_address),
    .bus_byteenable (bus_byteenable),
    .bus_data       (bus_data),
    .bus_write_done (bus_write_done),
    .queue_empty    (queue_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a request and wait (bounded) for wr_done; returns cycles waited.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [2:0] l,
                          input logic [31:0] d, output int cyc);
    logic seen;
    wr_do = 1'b1; wr_address = a; wr_length = l; wr_data = d;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (wr_done) seen = 1'b1;
    end
    wr_do = 1'b0;
    check({tag, "_done"}, seen, 1);
  endtask

  task automatic pop;
    bus_write_done = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_write_done = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [29:0] a, input logic [3:0] be,
                            input logic [31:0] d);
    check({tag, "_vld"},  bus_write_do, 1);
    check({tag, "_addr"}, bus_address, a);
    check({tag, "_be"},   bus_byteenable, be);
    check({tag, "_data"}, bus_data, d);
  endtask

  initial begin
    int  cyc;
    logic seen;
    rst = 1'b1; wr_do = 1'b0; wr_address = '0; wr_length = '0; wr_data = '0;
    bus_write_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld",   bus_write_do, 0);
    check("rst_empty", queue_empty, 1);
    check("rst_done",  wr_done, 0);
    check("rst_addr",  bus_address, 0);
    check("rst_be",    bus_byteenable, 0);
    check("rst_data",  bus_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned single beat
    do_write("al", 32'h0000_1000, 3'd4, 32'hAABB_CCDD, cyc);
    check("al_latency", cyc, 1);
    check("al_notempty", queue_empty, 0);
    check_head("al", 30'h400, 4'hF, 32'hAABB_CCDD);
    @(negedge clk);
    check("al_pulse_one", wr_done, 0);
    pop();
    check("al_drained", bus_write_do, 0);
    check("al_empty", queue_empty, 1);

    // Split across dwords
    do_write("sp", 32'h0000_1003, 3'd2, 32'h0000_1122, cyc);
    check_head("sp_b1", 30'h400, 4'h8, 32'h2200_0000);
    pop();
    check_head("sp_b2", 30'h401, 4'h1, 32'h0000_0011);
    pop();
    check("sp_drained", bus_write_do, 0);

    // Address wrap at top of memory
    do_write("wr", 32'hFFFF_FFFE, 3'd4, 32'h4433_2211, cyc);
    check_head("wr_b1", 30'h3FFF_FFFF, 4'hC, 32'h2211_0000);
    pop();
    check_head("wr_b2", 30'h0, 4'h3, 32'h0000_4433);
    pop();

    // Zero-length request: pulse, nothing queued
    do_write("z", 32'h0000_2000, 3'd0, 32'h1234_5678, cyc);
    check("z_latency", cyc, 1);
    check("z_novld", bus_write_do, 0);
    @(negedge clk);
    check("z_empty", queue_empty, 1);

    // Full queue back-pressure
    for (int unsigned k = 0; k < 4; k++)
      do_write("fq", 32'h0000_2000 + 32'(k * 4), 3'd4, 32'hD000_0000 + k, cyc);
    wr_do = 1'b1; wr_address = 32'h0000_2010; wr_length = 3'd4; wr_data = 32'hD000_0004;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (wr_done) seen = 1'b1;
    end
    check("fq_blocked", seen, 0);
    pop();
    check("fq_not_yet", wr_done, 0);
    do_write("fq5", 32'h0000_2010, 3'd4, 32'hD000_0004, cyc);
    for (int unsigned k = 1; k < 5; k++) begin
      check_head("fq_order", 30'h800 + 30'(k), 4'hF, 32'hD000_0000 + k);
      pop();
    end
    check("fq_drained", bus_write_do, 0);

    // Pop and split request in the same cycle with one free entry
    for (int unsigned k = 0; k < 3; k++)
      do_write("pp", 32'h0000_3000 + 32'(k * 4), 3'd4, 32'hE000_0000 + k, cyc);
    wr_do = 1'b1; wr_address = 32'h0000_3013; wr_length = 3'd4; wr_data = 32'h4433_2211;
    bus_write_done = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_write_done = 1'b0;
    check("pp_no_accept_at_pop", wr_done, 0);
    @(posedge clk); @(negedge clk);
    check("pp_accept_after_pop", wr_done, 1);
    wr_do = 1'b0;
    check_head("pp_h1", 30'hC01, 4'hF, 32'hE000_0001);
    pop();
    check_head("pp_h2", 30'hC02, 4'hF, 32'hE000_0002);
    pop();
    check_head("pp_s1", 30'hC04, 4'h8, 32'h1100_0000);
    pop();
    check_head("pp_s2", 30'hC05, 4'h7, 32'h0044_3322);
    pop();
    check("pp_drained", bus_write_do, 0);

    // Reset mid-operation with a coincident bus_write_done
    for (int unsigned k = 0; k < 3; k++)
      do_write("rs", 32'h0000_4000 + 32'(k * 4), 3'd4, 32'hF000_0000 + k, cyc);
    rst = 1'b1; bus_write_done = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; bus_write_done = 1'b0;
    check("rs_vld", bus_write_do, 0);
    check("rs_empty", queue_empty, 1);
    check("rs_addr", bus_address, 0);
    repeat (2) @(negedge clk);
    check("rs_no_stale", bus_write_do, 0);
    do_write("rs_new", 32'h0000_5004, 3'd1, 32'h0000_00AB, cyc);
    check_head("rs_new", 30'h1401, 4'h1, 32'h0000_00AB);
    pop();
    check("rs_final", bus_write_do, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
